// File: rtl/mem_responder_if.sv
// Request/response bus between the cache controller (master) and the
// memory responder (slave).
interface mem_responder_if;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  modport master (output rd, wr, addr, data_in,
                  input  data_out, stall, done, err);
  modport slave  (input  rd, wr, addr, data_in,
                  output data_out, stall, done, err);
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder: accepts one aligned read or write
// while idle, stalls for LATENCY cycles, then pulses done. Malformed
// requests (rd and wr together, or odd byte address) pulse err instead.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_idx;
  logic [15:0]         r_wdata;
  logic [15:0]         r_data_out;
  logic                r_err;
  logic [15:0]         r_mem [2**ADDR_W];

  logic                w_req;
  logic                w_bad;
  logic                w_accept;
  logic                w_stall;
  logic                w_done;

  assign w_req    = bus.rd | bus.wr;
  assign w_bad    = w_req & ((bus.rd & bus.wr) | bus.addr[0]);
  assign w_accept = (r_state == ST_IDLE) & w_req & ~w_bad;

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT -> DONE at LATENCY-1, DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'(LATENCY - 1)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode: stall for the whole operation, done only in the final cycle.
  always_comb begin
    w_stall = (r_state != ST_IDLE);
    w_done  = (r_state == ST_DONE);
  end

  // Request capture, latency counter, read data and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_err      <= 1'b0;
      r_data_out <= 16'h0000;
      r_op_wr    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 16'h0000;
    end else begin
      r_err <= (r_state == ST_IDLE) & w_bad;
      if (w_accept) begin
        r_op_wr <= bus.wr;
        r_idx   <= bus.addr[ADDR_W:1];
        r_wdata <= bus.data_in;
        r_cnt   <= 4'd1;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      // Read data is fetched on the edge entering DONE and held afterwards.
      if (r_state == ST_WAIT && w_next == ST_DONE && !r_op_wr)
        r_data_out <= r_mem[r_idx];
    end
  end

  // Storage commit on the edge leaving DONE; not cleared by reset, and a
  // reset in DONE suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst && r_state == ST_DONE && r_op_wr)
      r_mem[r_idx] <= r_wdata;
  end

  assign bus.data_out = r_data_out;
  assign bus.stall    = w_stall;
  assign bus.done     = w_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_mem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  mem_responder_if bus ();

  mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0; bus.data_in = 16'h0;
  endtask

  // One full operation. Checks stall/done/err in cycles 1..LAT, read data
  // in the done cycle, and the return to idle. Without hold, inputs are
  // scrambled while stalled; with hold, the request stays asserted.
  task automatic op(input string tag, input logic r, input logic w,
                    input logic [15:0] a, input logic [15:0] d,
                    input logic hold, input logic [15:0] exp_rd);
    bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk({tag, ".stall"}, bus.stall, 1'b1);
      chk({tag, ".done"},  bus.done, (k == LAT));
      chk({tag, ".err"},   bus.err, 1'b0);
      if (k == LAT && r) chk({tag, ".data"}, bus.data_out, exp_rd);
      if (!hold) begin
        bus.rd = 1'($urandom); bus.wr = 1'($urandom);
        bus.addr = 16'($urandom); bus.data_in = 16'($urandom);
      end
    end
    tick();
    chk({tag, ".idle_stall"}, bus.stall, 1'b0);
    chk({tag, ".idle_done"},  bus.done, 1'b0);
    idle_in();
    if (hold) begin
      tick();
      chk({tag, ".no_reissue"}, bus.stall, 1'b0);
      chk({tag, ".no_redone"},  bus.done, 1'b0);
    end
  endtask

  // Write aborted by reset asserted during cycle abort_k after acceptance.
  task automatic op_abort(input string tag, input logic [15:0] a,
                          input logic [15:0] d, input int abort_k);
    bus.wr = 1'b1; bus.addr = a; bus.data_in = d;
    for (int k = 1; k <= abort_k; k++) begin
      tick();
      idle_in();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk({tag, ".stall"}, bus.stall, 1'b0);
    chk({tag, ".done"},  bus.done, 1'b0);
    chk({tag, ".dout"},  bus.data_out, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk({tag, ".late_done"}, bus.done, 1'b0);
    end
  endtask

  // Malformed request: err pulses exactly one cycle, no stall, no done.
  task automatic bad_req(input string tag, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] exp_dout);
    bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = 16'hFFFF;
    tick();
    idle_in();
    chk({tag, ".err"},   bus.err, 1'b1);
    chk({tag, ".stall"}, bus.stall, 1'b0);
    chk({tag, ".done"},  bus.done, 1'b0);
    chk({tag, ".dout"},  bus.data_out, exp_dout);
    tick();
    chk({tag, ".err_off"}, bus.err, 1'b0);
    chk({tag, ".done2"},   bus.done, 1'b0);
  endtask

  initial begin
    // Reset with a request presented: it must be ignored.
    bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = 16'h0010; bus.data_in = 16'hDEAD;
    rst = 1'b0;
    tick(); tick();
    chk("rst.stall", bus.stall, 1'b0);
    chk("rst.done",  bus.done, 1'b0);
    chk("rst.err",   bus.err, 1'b0);
    chk("rst.dout",  bus.data_out, 16'h0000);
    idle_in();
    rst = 1'b1;
    tick();
    chk("rst.after", bus.stall, 1'b0);

    // Write then back-to-back read of the same word.
    op("wr_beef", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
    op("rd_beef", 1'b1, 1'b0, 16'h0010, 16'h0,    1'b0, 16'hBEEF);

    // Read held high across the whole stall: one access only.
    op("rd_hold", 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 16'hBEEF);

    // rd and wr together: rejected, storage untouched.
    op("wr_5555", 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0, 16'h0);
    bad_req("both", 1'b1, 1'b1, 16'h0020, 16'hBEEF);
    op("rd_5555", 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h5555);

    // Odd address read: rejected, data_out kept.
    bad_req("odd", 1'b1, 1'b0, 16'h0003, 16'h5555);

    // Writes aborted by reset during WAIT and during DONE do not commit.
    op("wr_7777", 1'b0, 1'b1, 16'h0040, 16'h7777, 1'b0, 16'h0);
    op_abort("abort_wait", 16'h0040, 16'h1234, 2);
    op("rd_7777a", 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h7777);
    op_abort("abort_done", 16'h0040, 16'h9999, LAT);
    op("rd_7777b", 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h7777);

    // Upper address bits alias onto the same word.
    op("wr_a5a5", 1'b0, 1'b1, 16'h0002, 16'hA5A5, 1'b0, 16'h0);
    op("rd_alias", 1'b1, 1'b0, 16'h0202, 16'h0, 1'b0, 16'hA5A5);

    // Earlier data still intact after all of the above.
    op("rd_beef2", 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
